axis_fir_decim: RTL and testbench

- Parametrised AXI-Stream FIR filter with optional integer decimation, round-and-saturate output scaling and full backpressure support.
- Successor to the single-rate 8-bit-coefficient FIR.
- Sits in the BPSK receive chain between the mixer/downconverter output and the symbol-timing stage. Used as a matched filter (DECIM=1) or as a decimating anti-alias filter (DECIM>1).

---
 rtl/fir_pkg.sv | 68 ++++++
 rtl/fir_tap.sv | 59 +++++
 rtl/axis_fir_decim.sv | 149 ++++++++++++++
 tb/tb_axis_fir_decim.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fir_pkg
// Description : Shared helpers for the AXI-Stream FIR decimator:
//               integer clog2, minimum accumulator width rule, and a
//               round-half-up / saturate helper that works on a wide
//               signed value with width arguments.
// Revision    : 1.0 - initial release
// ============================================================================
package fir_pkg;

    // Working width of the round/saturate helper; covers any sane ACC_WIDTH.
    localparam int RS_W = 128;

    typedef struct packed {
        logic                    sat;
        logic signed [RS_W-1:0]  value;
    } rs_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Smallest accumulator that cannot overflow for full-scale data/taps.
    function automatic int min_acc_width(input int data_w, input int coeff_w, input int n_taps);
        return data_w + coeff_w + clog2(n_taps);
    endfunction

    localparam int DEFAULT_ACC_WIDTH = min_acc_width(16, 8, 64);

    // r = (acc + 2^(shift-1)) >>> shift (shift==0: r = acc), then clamp to
    // the signed out_w range. value is returned sign-extended to RS_W bits.
    function automatic rs_t round_sat(input logic signed [RS_W-1:0] acc,
                                      input int shift, input int out_w);
        logic signed [RS_W-1:0] one;
        logic signed [RS_W-1:0] r;
        logic signed [RS_W-1:0] maxv;
        logic signed [RS_W-1:0] minv;
        rs_t                    res;
        one = {{(RS_W-1){1'b0}}, 1'b1};
        if (shift > 0) begin
            r = (acc + (one <<< (shift - 1))) >>> shift;
        end else begin
            r = acc;
        end
        maxv = (one <<< (out_w - 1)) - one;
        minv = -(one <<< (out_w - 1));
        res.sat = (r > maxv) || (r < minv);
        if (r > maxv) begin
            res.value = maxv;
        end else if (r < minv) begin
            res.value = minv;
        end else begin
            res.value = r;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fir_tap.sv
`default_nettype none
// ============================================================================
// Module      : fir_tap
// Description : One transposed-form FIR stage: o = coeff*x + psum_in.
//               With HAS_REG=1 the sum is captured in an enable-gated
//               register; with HAS_REG=0 it is passed through combinationally
//               (used for tap 0, whose sum is the filter output).
// Ports       : clk, rst (sync, active-high), i_en (advance), i_x (sample),
//               i_coeff (tap weight), i_psum (from next tap), o_psum.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_tap
    import fir_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 8,
    parameter int ACC_WIDTH   = 40,
    parameter int HAS_REG     = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic signed [DATA_WIDTH-1:0]  i_x,
    input  logic signed [COEFF_WIDTH-1:0] i_coeff,
    input  logic signed [ACC_WIDTH-1:0]   i_psum,
    output logic signed [ACC_WIDTH-1:0]   o_psum
);

    localparam int P_W = DATA_WIDTH + COEFF_WIDTH;

    logic signed [P_W-1:0]       w_prod;
    logic signed [ACC_WIDTH-1:0] w_sum;

    // Both operands are sign-extended to the full product width, so the
    // truncated product is exact.
    assign w_prod = $signed({{DATA_WIDTH{i_coeff[COEFF_WIDTH-1]}}, i_coeff})
                  * $signed({{COEFF_WIDTH{i_x[DATA_WIDTH-1]}}, i_x});
    assign w_sum  = $signed({{(ACC_WIDTH-P_W){w_prod[P_W-1]}}, w_prod}) + i_psum;

    generate
        if (HAS_REG != 0) begin : g_reg
            logic signed [ACC_WIDTH-1:0] r_psum;
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_psum <= '0;
                end else if (i_en) begin
                    r_psum <= w_sum;
                end
            end
            assign o_psum = r_psum;
        end else begin : g_comb
            logic w_unused;
            assign w_unused = ^{clk, rst, i_en};
            assign o_psum   = w_sum;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/axis_fir_decim.sv
`default_nettype none
// ============================================================================
// Module      : axis_fir_decim
// Description : AXI-Stream transposed-form FIR with integer decimation,
//               round-half-up / saturate output scaling and backpressure.
// Ports       : s00_axis_* slave stream (sample in tdata[DATA_WIDTH-1:0]),
//               m00_axis_* master stream (sign-extended result),
//               coeffs (h[k] at index k, quasi-static),
//               sat_sticky / sat_clear saturation flag.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_fir_decim
    import fir_pkg::*;
#(
    parameter int C_S00_AXIS_TDATA_WIDTH = 32,
    parameter int C_M00_AXIS_TDATA_WIDTH = 32,
    parameter int DATA_WIDTH             = 16,
    parameter int COEFF_WIDTH            = 8,
    parameter int NUM_COEFFS             = 64,
    parameter int ACC_WIDTH              = 40,
    parameter int OUT_WIDTH              = 16,
    parameter int OUT_SHIFT              = 7,
    parameter int DECIM                  = 1
) (
    input  logic                                  s00_axis_aclk,
    input  logic                                  s00_axis_areset,
    input  logic                                  s00_axis_tvalid,
    output logic                                  s00_axis_tready,
    input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                  s00_axis_tlast,
    input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0]   s00_axis_tstrb,
    input  logic signed [COEFF_WIDTH-1:0]         coeffs [NUM_COEFFS],
    output logic                                  m00_axis_tvalid,
    input  logic                                  m00_axis_tready,
    output logic [C_M00_AXIS_TDATA_WIDTH-1:0]     m00_axis_tdata,
    output logic                                  m00_axis_tlast,
    output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]   m00_axis_tstrb,
    output logic                                  sat_sticky,
    input  logic                                  sat_clear
);

    localparam int PH_W = (DECIM > 1) ? clog2(DECIM) : 1;

    logic                                 clk;
    logic                                 rst;
    logic signed [DATA_WIDTH-1:0]         w_x;
    logic signed [ACC_WIDTH-1:0]          w_psum [NUM_COEFFS+1];
    logic signed [ACC_WIDTH-1:0]          w_acc;
    logic                                 w_tready;
    logic                                 w_accept;
    logic                                 w_emit;
    rs_t                                  w_rs;
    logic                                 w_unused;

    logic [PH_W-1:0]                      r_phase;
    logic                                 r_valid;
    logic                                 r_last;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0]    r_data;
    logic [C_M00_AXIS_TDATA_WIDTH/8-1:0]  r_strb;
    logic                                 r_sat;

    assign clk = s00_axis_aclk;
    assign rst = s00_axis_areset;
    assign w_x = $signed(s00_axis_tdata[DATA_WIDTH-1:0]);

    // Tap chain: tap k adds h[k]*x to the partial sum of tap k+1.
    // Tap 0 is combinational, so w_psum[0] is y[n] for the beat on the bus.
    assign w_psum[NUM_COEFFS] = '0;

    generate
        for (genvar k = 0; k < NUM_COEFFS; k++) begin : g_tap
            fir_tap #(
                .DATA_WIDTH  (DATA_WIDTH),
                .COEFF_WIDTH (COEFF_WIDTH),
                .ACC_WIDTH   (ACC_WIDTH),
                .HAS_REG     ((k == 0) ? 0 : 1)
            ) u_tap (
                .clk     (clk),
                .rst     (rst),
                .i_en    (w_accept),
                .i_x     (w_x),
                .i_coeff (coeffs[k]),
                .i_psum  (w_psum[k+1]),
                .o_psum  (w_psum[k])
            );
        end
    endgenerate

    assign w_acc = w_psum[0];

    // A new beat may enter whenever the output slot is free or draining now.
    assign w_tready = !rst && (!r_valid || m00_axis_tready);
    assign w_accept = s00_axis_tvalid && w_tready;
    assign w_emit   = w_accept && ((r_phase == '0) || s00_axis_tlast);

    assign w_rs = round_sat($signed({{(RS_W-ACC_WIDTH){w_acc[ACC_WIDTH-1]}}, w_acc}),
                            OUT_SHIFT, OUT_WIDTH);

    // Decimation phase; a tlast beat restarts the count for the next packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_phase <= '0;
        end else if (w_accept) begin
            if (s00_axis_tlast || (r_phase == PH_W'(DECIM - 1))) begin
                r_phase <= '0;
            end else begin
                r_phase <= r_phase + PH_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_strb  <= '0;
            r_sat   <= 1'b0;
        end else begin
            if (w_emit) begin
                r_valid <= 1'b1;
                r_last  <= s00_axis_tlast;
                r_data  <= w_rs.value[C_M00_AXIS_TDATA_WIDTH-1:0];
                r_strb  <= '1;
            end else if (m00_axis_tready) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
                r_strb  <= '0;
            end
            // Setting takes priority over a coincident clear.
            if (w_emit && w_rs.sat) begin
                r_sat <= 1'b1;
            end else if (sat_clear) begin
                r_sat <= 1'b0;
            end
        end
    end

    assign s00_axis_tready = w_tready;
    assign m00_axis_tvalid = r_valid;
    assign m00_axis_tdata  = r_data;
    assign m00_axis_tlast  = r_last;
    assign m00_axis_tstrb  = r_strb;
    assign sat_sticky      = r_sat;

    assign w_unused = ^{s00_axis_tstrb, s00_axis_tdata, w_rs};

endmodule
`default_nettype wire

// File: tb/tb_axis_fir_decim.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_fir_decim
// Description : Self-checking bench for axis_fir_decim. Three instances:
//               A (8 taps, no shift, DECIM=1) with a queue scoreboard,
//               D (DECIM=4) and R (OUT_SHIFT=7) driven from vector tables.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_axis_fir_decim;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } exp_t;

    // ---------------- instance A ----------------
    logic              a_rst = 1'b1;
    logic              a_s_valid = 1'b0;
    logic              a_s_ready;
    logic [31:0]       a_s_data = '0;
    logic              a_s_last = 1'b0;
    logic [3:0]        a_s_strb = 4'hF;
    logic signed [7:0] a_coeffs [8];
    logic              a_m_valid;
    logic              a_m_ready = 1'b1;
    logic [31:0]       a_m_data;
    logic              a_m_last;
    logic [3:0]        a_m_strb;
    logic              a_sat;
    logic              a_clr = 1'b0;
    int                bp_mode = 0;   // 0: ready=1, 1: random, 2: ready=0
    exp_t              a_q [$];
    logic signed [15:0] hist [8];

    axis_fir_decim #(.NUM_COEFFS(8), .OUT_SHIFT(0), .DECIM(1)) u_a (
        .s00_axis_aclk(clk), .s00_axis_areset(a_rst),
        .s00_axis_tvalid(a_s_valid), .s00_axis_tready(a_s_ready),
        .s00_axis_tdata(a_s_data), .s00_axis_tlast(a_s_last), .s00_axis_tstrb(a_s_strb),
        .coeffs(a_coeffs),
        .m00_axis_tvalid(a_m_valid), .m00_axis_tready(a_m_ready),
        .m00_axis_tdata(a_m_data), .m00_axis_tlast(a_m_last), .m00_axis_tstrb(a_m_strb),
        .sat_sticky(a_sat), .sat_clear(a_clr)
    );

    // ---------------- instance D ----------------
    logic              d_rst = 1'b1;
    logic              d_s_valid = 1'b0;
    logic              d_s_ready;
    logic [31:0]       d_s_data = '0;
    logic              d_s_last = 1'b0;
    logic [3:0]        d_s_strb = 4'hF;
    logic signed [7:0] d_coeffs [8];
    logic              d_m_valid;
    logic              d_m_ready = 1'b1;
    logic [31:0]       d_m_data;
    logic              d_m_last;
    logic [3:0]        d_m_strb;
    logic              d_sat;
    logic              d_clr = 1'b0;

    axis_fir_decim #(.NUM_COEFFS(8), .OUT_SHIFT(0), .DECIM(4)) u_d (
        .s00_axis_aclk(clk), .s00_axis_areset(d_rst),
        .s00_axis_tvalid(d_s_valid), .s00_axis_tready(d_s_ready),
        .s00_axis_tdata(d_s_data), .s00_axis_tlast(d_s_last), .s00_axis_tstrb(d_s_strb),
        .coeffs(d_coeffs),
        .m00_axis_tvalid(d_m_valid), .m00_axis_tready(d_m_ready),
        .m00_axis_tdata(d_m_data), .m00_axis_tlast(d_m_last), .m00_axis_tstrb(d_m_strb),
        .sat_sticky(d_sat), .sat_clear(d_clr)
    );

    // ---------------- instance R ----------------
    logic              r_rst = 1'b1;
    logic              r_s_valid = 1'b0;
    logic              r_s_ready;
    logic [31:0]       r_s_data = '0;
    logic              r_s_last = 1'b0;
    logic [3:0]        r_s_strb = 4'hF;
    logic signed [7:0] r_coeffs [8];
    logic              r_m_valid;
    logic              r_m_ready = 1'b1;
    logic [31:0]       r_m_data;
    logic              r_m_last;
    logic [3:0]        r_m_strb;
    logic              r_sat;
    logic              r_clr = 1'b0;

    axis_fir_decim #(.NUM_COEFFS(8), .OUT_SHIFT(7), .OUT_WIDTH(16), .DECIM(1)) u_r (
        .s00_axis_aclk(clk), .s00_axis_areset(r_rst),
        .s00_axis_tvalid(r_s_valid), .s00_axis_tready(r_s_ready),
        .s00_axis_tdata(r_s_data), .s00_axis_tlast(r_s_last), .s00_axis_tstrb(r_s_strb),
        .coeffs(r_coeffs),
        .m00_axis_tvalid(r_m_valid), .m00_axis_tready(r_m_ready),
        .m00_axis_tdata(r_m_data), .m00_axis_tlast(r_m_last), .m00_axis_tstrb(r_m_strb),
        .sat_sticky(r_sat), .sat_clear(r_clr)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk_exp(input logic [31:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        return e;
    endfunction

    // Direct-form reference: y = sum h[k]*x[n-k], then round and clamp.
    function automatic logic [31:0] ref_out(input int shift, input int outw);
        longint acc;
        longint r;
        longint maxv;
        longint minv;
        acc = 0;
        for (int k = 0; k < 8; k++) acc += longint'(a_coeffs[k]) * longint'(hist[k]);
        r    = (shift > 0) ? ((acc + (longint'(1) <<< (shift - 1))) >>> shift) : acc;
        maxv = (longint'(1) <<< (outw - 1)) - 1;
        minv = -(longint'(1) <<< (outw - 1));
        if (r > maxv) r = maxv;
        if (r < minv) r = minv;
        return 32'(r);
    endfunction

    task automatic model_push(input logic signed [15:0] x);
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = x;
    endtask

    // Downstream ready generator for instance A.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       a_m_ready = 1'b1;
                1:       a_m_ready = 1'($urandom_range(0, 1));
                default: a_m_ready = 1'b0;
            endcase
        end
    end

    // Scoreboard monitor for A, sampled on the falling edge.
    always @(negedge clk) begin
        if (a_rst) begin
            a_q.delete();
        end else begin
            chk("a_tready_rule", a_s_ready, (!a_m_valid || a_m_ready));
            chk("a_tvalid", a_m_valid, (a_q.size() != 0));
            if (a_m_valid && a_q.size() != 0) begin
                chk("a_tdata", a_m_data, a_q[0].data);
                chk("a_tlast", a_m_last, a_q[0].last);
                chk("a_tstrb", a_m_strb, 4'hF);
                if (a_m_ready) void'(a_q.pop_front());
            end
        end
    end

    task automatic a_send(input logic signed [15:0] x, input logic last, input exp_t e);
        int n;
        n = 0;
        a_s_valid = 1'b1;
        a_s_data  = {16'($urandom), x};
        a_s_last  = last;
        @(negedge clk);
        while (!a_s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!a_s_ready) begin
            checks++;
            errors++;
            $display("FAIL a_send_timeout: got tready=0 expected 1");
        end
        @(posedge clk);
        #1;
        if (n < 200) a_q.push_back(e);
        a_s_valid = 1'b0;
        a_s_last  = 1'b0;
    endtask

    task automatic a_drain();
        int n;
        n = 0;
        while (a_q.size() != 0 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (a_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL a_drain_timeout: got %0d pending expected 0", a_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic a_reset(input logic signed [7:0] h [8]);
        @(posedge clk);
        #1;
        a_rst     = 1'b1;
        a_s_valid = 1'b0;
        a_coeffs  = h;
        @(negedge clk);
        chk("a_tready_in_reset", a_s_ready, 0);
        @(posedge clk);
        #1;
        a_rst = 1'b0;
        for (int k = 0; k < 8; k++) hist[k] = '0;
        @(negedge clk);
        chk("a_reset_tvalid", a_m_valid, 0);
        chk("a_reset_tdata", a_m_data, 0);
        chk("a_reset_tlast", a_m_last, 0);
        chk("a_reset_tstrb", a_m_strb, 0);
        chk("a_reset_sat", a_sat, 0);
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic signed [15:0] x;
        logic               last;
        logic [31:0]        exp;
    } vec_t;

    typedef struct {
        logic signed [15:0] x;
        logic               last;
        logic               ev;
        logic [31:0]        ed;
        logic               el;
    } dvec_t;

    typedef struct {
        logic               rst;
        logic               sel;
        logic signed [15:0] x;
        logic               clr;
        logic [31:0]        ed;
        logic               es;
    } rvec_t;

    vec_t               imp [10];
    dvec_t              dv [32];
    rvec_t              rv [10];
    logic signed [7:0]  h_ramp [8];
    logic signed [7:0]  h_ones [8];
    logic signed [7:0]  h_rand [8];

    initial begin
        logic signed [15:0] x;
        logic               l;
        int                 t0;
        int                 t1;
        logic [31:0]        held;
        int                 j;

        // ---- vector tables ----
        for (int k = 0; k < 8; k++) begin
            h_ramp[k] = 8'(k + 1);
            h_ones[k] = 8'sd1;
            d_coeffs[k] = (k == 0) ? 8'sd1 : 8'sd0;
        end
        for (int i = 0; i < 10; i++) begin
            imp[i].x    = (i == 0) ? 16'sd1 : 16'sd0;
            imp[i].last = (i == 9);
            imp[i].exp  = (i < 8) ? 32'(i + 1) : 32'd0;
        end
        held = '0;
        for (int i = 0; i < 32; i++) begin
            j = (i < 16) ? i : i - 16;
            dv[i].x    = 16'(j);
            dv[i].last = (i >= 16) && (j == 9);
            if (i < 16) dv[i].ev = (j % 4 == 0);
            else        dv[i].ev = (j == 0) || (j == 4) || (j == 8) || (j == 9) || (j == 10) || (j == 14);
            if (dv[i].ev) held = 32'(j);
            dv[i].ed = held;
            dv[i].el = dv[i].last;
        end
        rv[0] = '{1'b1, 1'b0,  16'sd32767, 1'b0, 32'h0000_7EFF, 1'b0};
        rv[1] = '{1'b0, 1'b0,  16'sd32767, 1'b0, 32'h0000_7FFF, 1'b1};
        rv[2] = '{1'b0, 1'b0,  16'sd32767, 1'b1, 32'h0000_7FFF, 1'b1};
        rv[3] = '{1'b1, 1'b0, -16'sd32768, 1'b0, 32'hFFFF_8100, 1'b0};
        rv[4] = '{1'b0, 1'b0, -16'sd32768, 1'b0, 32'hFFFF_8000, 1'b1};
        rv[5] = '{1'b1, 1'b1,  16'sd64,    1'b0, 32'h0000_0001, 1'b0};
        rv[6] = '{1'b0, 1'b1,  16'sd63,    1'b0, 32'h0000_0000, 1'b0};
        rv[7] = '{1'b0, 1'b1, -16'sd64,    1'b0, 32'h0000_0000, 1'b0};
        rv[8] = '{1'b0, 1'b1, -16'sd65,    1'b0, 32'hFFFF_FFFF, 1'b0};
        rv[9] = '{1'b0, 1'b1,  16'sd32767, 1'b0, 32'h0000_0100, 1'b0};

        for (int k = 0; k < 8; k++) begin
            a_coeffs[k] = '0;
            r_coeffs[k] = '0;
            hist[k]     = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        d_rst = 1'b0;
        r_rst = 1'b0;

        // ---- A: impulse response h[k]=k+1 ----
        a_reset(h_ramp);
        for (int i = 0; i < 10; i++) a_send(imp[i].x, imp[i].last, mk_exp(imp[i].exp, imp[i].last));
        a_drain();

        // ---- A: step 100 under random backpressure, h all ones ----
        a_reset(h_ones);
        bp_mode = 1;
        for (int i = 0; i < 20; i++) begin
            a_send(16'sd100, (i == 19), mk_exp(32'(((i + 1 < 8) ? i + 1 : 8) * 100), (i == 19)));
        end
        a_drain();

        // ---- A: random samples and tlast under backpressure ----
        for (int k = 0; k < 8; k++) h_rand[k] = 8'(int'($urandom_range(0, 40)) - 20);
        a_reset(h_rand);
        for (int i = 0; i < 200; i++) begin
            x = 16'(int'($urandom_range(0, 8000)) - 4000);
            l = 1'($urandom_range(0, 9) == 0);
            model_push(x);
            a_send(x, l, mk_exp(ref_out(0, 16), l));
        end
        a_drain();

        // ---- A: reset while the output is stalled ----
        a_reset(h_ones);
        bp_mode = 0;
        a_send(16'sd300, 1'b0, mk_exp(32'd300, 1'b0));
        a_send(16'sd400, 1'b0, mk_exp(32'd700, 1'b0));
        a_drain();
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #1;
        a_send(16'sd500, 1'b0, mk_exp(32'd1200, 1'b0));
        repeat (3) @(negedge clk);
        chk("a_stalled_tvalid", a_m_valid, 1);
        a_reset(h_ramp);
        bp_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) a_send(imp[i].x, imp[i].last, mk_exp(imp[i].exp, imp[i].last));
        a_drain();

        // ---- A: full throughput, 1000 back-to-back samples ----
        for (int k = 0; k < 8; k++) h_rand[k] = 8'(int'($urandom_range(0, 40)) - 20);
        a_reset(h_rand);
        t0 = cyc;
        for (int i = 0; i < 1000; i++) begin
            x = 16'(int'($urandom_range(0, 8000)) - 4000);
            model_push(x);
            a_send(x, (i == 999), mk_exp(ref_out(0, 16), (i == 999)));
        end
        t1 = cyc;
        chk("a_throughput_cycles", 32'(t1 - t0), 32'd1000);
        a_drain();

        // ---- D: decimation by 4, ramp then ramp with tlast on sample 9 ----
        for (int i = 0; i < 32; i++) begin
            d_s_valid = 1'b1;
            d_s_data  = {16'hA5A5, dv[i].x};
            d_s_last  = dv[i].last;
            @(posedge clk);
            #1;
            d_s_valid = 1'b0;
            d_s_last  = 1'b0;
            chk("d_tvalid", d_m_valid, dv[i].ev);
            chk("d_tdata", d_m_data, dv[i].ed);
            if (dv[i].ev) chk("d_tlast", d_m_last, dv[i].el);
        end

        // ---- R: rounding and saturation ----
        for (int i = 0; i < 10; i++) begin
            if (rv[i].rst) begin
                for (int k = 0; k < 8; k++) r_coeffs[k] = rv[i].sel ? ((k == 0) ? 8'sd1 : 8'sd0) : 8'sd127;
                r_rst = 1'b1;
                @(posedge clk);
                #1;
                r_rst = 1'b0;
            end
            r_s_valid = 1'b1;
            r_s_data  = {16'h0000, rv[i].x};
            r_clr     = rv[i].clr;
            @(posedge clk);
            #1;
            r_s_valid = 1'b0;
            r_clr     = 1'b0;
            chk("r_tvalid", r_m_valid, 1);
            chk("r_tdata", r_m_data, rv[i].ed);
            chk("r_sat_sticky", r_sat, rv[i].es);
        end
        // Saturate, then clear the flag while idle.
        for (int k = 0; k < 8; k++) r_coeffs[k] = 8'sd127;
        r_rst = 1'b1;
        @(posedge clk);
        #1;
        r_rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_s_valid = 1'b1;
            r_s_data  = 32'h0000_7FFF;
            @(posedge clk);
            #1;
        end
        r_s_valid = 1'b0;
        chk("r_sat_before_clear", r_sat, 1);
        r_clr = 1'b1;
        @(posedge clk);
        #1;
        r_clr = 1'b0;
        chk("r_sat_after_clear", r_sat, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
